mips_mem_access_unit: RTL

- Two-channel Avalon-MM master that serves instruction-fetch and data load/store requests from the multicycle MIPS core.
- Handles arbitration, waitrequest stalls, byte-lane steering with byteenable generation, load sign/zero extension and alignment faults.
- Sits between the core's control path and the memory bus, replacing direct core-driven address/read/write.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/mips_mem_access_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MIPS memory access unit.
//
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD : d_size encodings
//   state_t                         : IDLE, ACCESS, FAULT
//   chan_t                          : CH_IF (instruction fetch), CH_D (data)
//   is_misaligned()                 : alignment / reserved-size check
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      FAULT  = 2'd2
   } state_t;

   typedef enum logic {
      CH_IF = 1'b0,
      CH_D  = 1'b1
   } chan_t;

   // The reserved size is reported as a fault rather than guessed at,
   // so it is treated as misaligned at every offset.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory access unit.
//
// Store side: builds byteenable and replicates the right-justified store
// data onto every lane so the enabled lanes carry the correct bytes.
// Load side: pulls the addressed byte/half out of the bus word and
// sign- or zero-extends it. Lanes are little-endian.
//
// Ports:
//   size        in  2   access size (SZ_*)
//   off         in  2   byte offset within the word (addr[1:0])
//   load_signed in  1   sign-extend loaded byte/half
//   store_data  in  32  right-justified store data
//   bus_rdata   in  32  raw Avalon readdata
//   lane_be     out 4   byteenable for the access
//   lane_wdata  out 32  lane-steered writedata
//   load_data   out 32  extended load result
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        load_signed,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  lane_be,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Store steering: replicating the data means only byteenable has to
   // depend on the offset; the bus ignores the disabled lanes.
   always_comb begin
      lane_be    = 4'h0;
      lane_wdata = 32'h0;
      case (size)
         SZ_BYTE: begin
            lane_be    = 4'b0001 << off;
            lane_wdata = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            lane_be    = 4'b0011 << off;
            lane_wdata = {2{store_data[15:0]}};
         end
         SZ_WORD: begin
            lane_be    = 4'hF;
            lane_wdata = store_data;
         end
         default: begin
            lane_be    = 4'h0;
            lane_wdata = 32'h0;
         end
      endcase
   end

   // Load extraction: shift the addressed lane down to bit 0, then extend.
   // Word accesses are always at offset 0, so the shifted word is the raw word.
   always_comb begin
      shifted   = bus_rdata >> {off, 3'b000};
      load_data = 32'h0;
      case (size)
         SZ_BYTE: load_data = load_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
         SZ_HALF: load_data = load_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/mips_mem_access_unit.sv
// Two-channel Avalon-MM master for the multicycle MIPS core.
//
// Serves instruction fetches and data loads/stores over one Avalon bus.
// Data requests win over fetches when both are pending in IDLE. Misaligned
// requests and the reserved size fault without touching the bus.
//
// Build option: define MEM_TIMEOUT_EN to enable a waitrequest timeout
// (parameter TIMEOUT_CYCLES); without it the unit waits indefinitely.
//
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_ack/if_rdata/if_fault   fetch channel
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata
//                  -> d_ack/d_rdata/d_fault      data channel
//   address/read/write/writedata/byteenable
//   readdata/waitrequest                         Avalon-MM master
//   busy                                         high when not IDLE
module mips_mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   output logic              if_fault,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_signed,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              d_fault,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic [31:0]       readdata,
   input  logic              waitrequest,
   output logic              busy
);

   state_t            state, state_nxt;
   chan_t             lat_ch;
   logic [ADDR_W-1:0] lat_addr;
   logic [1:0]        lat_size;
   logic              lat_we;
   logic              lat_signed;
   logic [31:0]       lat_wdata;

   logic              accept_d, accept_if, new_fault;
   logic              bus_done, timeout_hit;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata, load_data;

   mem_lane_align u_align (
      .size        (lat_size),
      .off         (lat_addr[1:0]),
      .load_signed (lat_signed),
      .store_data  (lat_wdata),
      .bus_rdata   (readdata),
      .lane_be     (lane_be),
      .lane_wdata  (lane_wdata),
      .load_data   (load_data)
   );

   // Request selection in IDLE: data has priority; a fetch is always a word.
   always_comb begin
      accept_d  = (state == IDLE) && d_req;
      accept_if = (state == IDLE) && !d_req && if_req;
      new_fault = accept_d ? is_misaligned(d_size, d_addr[1:0])
                           : is_misaligned(SZ_WORD, if_addr[1:0]);
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0] stall_cnt;

   // Stall counter: held at zero outside ACCESS so every access starts fresh.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (state != ACCESS) begin
         stall_cnt <= '0;
      end else if (waitrequest) begin
         stall_cnt <= stall_cnt + TCNT_W'(1);
      end
   end

   assign timeout_hit = (state == ACCESS) && waitrequest &&
                        (stall_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // The access ends either on a normal handshake or on a timeout.
   assign bus_done = (state == ACCESS) && (!waitrequest || timeout_hit);

   // Next-state and Avalon outputs. Bus signals come only from latched
   // values, so they stay stable through waitrequest and drop to zero the
   // moment the state register is reset.
   always_comb begin
      state_nxt  = state;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      writedata  = 32'h0;
      byteenable = 4'h0;
      case (state)
         IDLE: begin
            if (accept_d || accept_if) begin
               state_nxt = new_fault ? FAULT : ACCESS;
            end
         end
         ACCESS: begin
            read       = !lat_we;
            write      = lat_we;
            address    = {lat_addr[ADDR_W-1:2], 2'b00};
            byteenable = (lat_ch == CH_IF) ? 4'hF : lane_be;
            writedata  = lat_we ? lane_wdata : 32'h0;
            if (bus_done) begin
               state_nxt = IDLE;
            end
         end
         FAULT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request latch: captured once on acceptance and held for the whole access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_ch     <= CH_IF;
         lat_addr   <= '0;
         lat_size   <= SZ_BYTE;
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         lat_wdata  <= 32'h0;
      end else if (accept_d) begin
         lat_ch     <= CH_D;
         lat_addr   <= d_addr;
         lat_size   <= d_size;
         lat_we     <= d_we;
         lat_signed <= d_signed;
         lat_wdata  <= d_wdata;
      end else if (accept_if) begin
         lat_ch     <= CH_IF;
         lat_addr   <= if_addr;
         lat_size   <= SZ_WORD;
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         lat_wdata  <= 32'h0;
      end
   end

   // Completion pulses. Acks, faults and rdata are single-cycle; rdata is
   // zero outside its ack cycle and for stores, faults and timeouts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_ack   <= 1'b0;
         if_fault <= 1'b0;
         if_rdata <= 32'h0;
         d_ack    <= 1'b0;
         d_fault  <= 1'b0;
         d_rdata  <= 32'h0;
      end else begin
         if_ack   <= 1'b0;
         if_fault <= 1'b0;
         if_rdata <= 32'h0;
         d_ack    <= 1'b0;
         d_fault  <= 1'b0;
         d_rdata  <= 32'h0;
         if (bus_done) begin
            if (lat_ch == CH_D) begin
               d_ack   <= 1'b1;
               d_fault <= timeout_hit;
               d_rdata <= (timeout_hit || lat_we) ? 32'h0 : load_data;
            end else begin
               if_ack   <= 1'b1;
               if_fault <= timeout_hit;
               if_rdata <= timeout_hit ? 32'h0 : readdata;
            end
         end else if (state == FAULT) begin
            if (lat_ch == CH_D) begin
               d_ack   <= 1'b1;
               d_fault <= 1'b1;
            end else begin
               if_ack   <= 1'b1;
               if_fault <= 1'b1;
            end
         end
      end
   end

endmodule
